univ_shift_reg: RTL and testbench
=================================

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width (legal range 2..64).
REQ-002 SHALL have parameter RST_VAL, default all-zero, value loaded into q on reset.
REQ-003 SHALL have derived localparam CNT_W = clog2(WIDTH+1), width of the shift-count field.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port en  input  1  single-cycle operation enable (idle only).
REQ-007 SHALL have port mode  input  3  operation select: HOLD, LOAD, SHL, SHR, ROL, ROR, CLR.
REQ-008 SHALL have port d  input  WIDTH  parallel load data.
REQ-009 SHALL have port sin_l  input  1  serial input at bit 0 for SHL.
REQ-010 SHALL have port sin_r  input  1  serial input at bit WIDTH-1 for SHR.
REQ-011 SHALL have port start  input  1  begin multi-cycle burst shift.
REQ-012 SHALL have port shamt  input  CNT_W  burst shift count.
REQ-013 SHALL have port q  output  WIDTH  registered contents.
REQ-014 SHALL have port sout_l  output  1  equals q[WIDTH-1], combinational.
REQ-015 SHALL have port sout_r  output  1  equals q[0], combinational.
REQ-016 SHALL have port busy  output  1  high while burst in progress.
REQ-017 SHALL have port done  output  1  one-cycle pulse at burst completion.

Function
REQ-018 SHALL implement FSM states IDLE, SHIFT, DONE; IDLE->SHIFT on start with shamt>0 and shift-type mode; IDLE->DONE on start otherwise; SHIFT->DONE when remaining count reaches 0; DONE->IDLE unconditionally.
REQ-019 In IDLE with en=1 and start=0, SHALL apply mode once at next edge: HOLD q unchanged; LOAD q=d; SHL q={q[W-2:0],sin_l}; SHR q={sin_r,q[W-1:1]}; ROL q={q[W-2:0],q[W-1]}; ROR q={q[0],q[W-1:1]}; CLR q=RST_VAL.
REQ-020 Mode encodings 7 (unused) SHALL behave as HOLD.
REQ-021 In IDLE with en=0 and start=0, q SHALL hold.
REQ-022 start and en both high in IDLE: start SHALL win; en ignored that cycle.
REQ-023 On accepted start, mode, sin_l and sin_r SHALL be latched; burst uses latched values, not live inputs.
REQ-024 Burst SHALL perform exactly min(shamt, WIDTH) shift steps, one per cycle, first step at the edge after start.
REQ-025 busy SHALL be high from the edge accepting start through the last shift edge; low in IDLE and DONE.
REQ-026 done SHALL be high exactly one cycle, in DONE state, immediately after the last step (or one cycle after start for zero-length bursts).
REQ-027 start with shamt=0 or non-shift mode SHALL leave q unchanged and still produce done.
REQ-028 en, mode, d, start and shamt SHALL be ignored while busy or done is high.

Reset
REQ-029 rst low SHALL immediately force q=RST_VAL, state=IDLE, busy=0, done=0, count=0, independent of clk.
REQ-030 rst asserted mid-burst SHALL abort the burst with no done pulse.
REQ-031 First operation SHALL be accepted at the first rising edge after rst deasserts.

Structure
REQ-032 Package univ_shift_pkg SHALL hold the mode enum (HOLD=0, LOAD=1, SHL=2, SHR=3, ROL=4, ROR=5, CLR=6) and the FSM state enum.
REQ-033 Storage SHALL be WIDTH instances of sub-module dff_en_arst (1-bit D flop, enable, async active-low reset, per-bit reset value); next-state mux and FSM in the top.

Verification
REQ-034 WIDTH=8, rst low, then high, clk running -> q=0x00, busy=0, done=0.
REQ-035 en=1 LOAD d=0xA5, then SHL sin_l=1 -> q=0xA5 then 0x4B; then ROR -> 0xA5.
REQ-036 q=0x81, start ROL shamt=3 -> busy high 3 cycles, q=0x03,0x06,0x0C, done pulse next cycle, mode toggled mid-burst has no effect.
REQ-037 start shamt=12 (>WIDTH) SHR sin_r=0 on q=0xFF -> 8 steps, q=0x00, single done pulse.
REQ-038 rst pulsed low between clock edges during burst -> q=RST_VAL immediately, busy=0, no done.
REQ-039 start and en=1 LOAD same cycle with shamt=0 -> q unchanged, done one cycle later.

Source files
------------

// File: rtl/univ_shift_pkg.sv
// Shared types for the universal shift register: operation modes, burst FSM
// states and a helper that classifies which modes take part in a burst.
package univ_shift_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_LOAD = 3'd1,
    MODE_SHL  = 3'd2,
    MODE_SHR  = 3'd3,
    MODE_ROL  = 3'd4,
    MODE_ROR  = 3'd5,
    MODE_CLR  = 3'd6
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // True for the four modes that move bits; only these run a multi-cycle burst.
  function automatic logic is_shift_mode(input logic [2:0] m);
    logic r;
    case (m)
      MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR: r = 1'b1;
      default:                                r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/univ_shift_reg_dff_en_arst.sv
// One storage bit: D flop with load enable and asynchronous active-low reset
// to a per-instance reset value.
module dff_en_arst #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);

  // Storage bit: reset wins asynchronously, otherwise load when enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: single-cycle HOLD/LOAD/SHL/SHR/ROL/ROR/CLR when
// idle, plus a multi-cycle burst shift of up to WIDTH steps driven by start.
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  localparam int              CNT_W   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [CNT_W-1:0] shamt,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       lmode_q, lmode_d;
  logic             lsin_l_q, lsin_l_d;
  logic             lsin_r_q, lsin_r_d;

  logic [WIDTH-1:0] q_q, q_d;
  logic             q_en_s;
  logic [2:0]       op_mode_s;
  logic             op_sin_l_s;
  logic             op_sin_r_s;
  logic [CNT_W-1:0] shamt_clip_s;

  // A burst never needs more than WIDTH steps to reach its final value.
  assign shamt_clip_s = (shamt > CNT_MAX) ? CNT_MAX : shamt;

  // FSM and burst-context registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= CNT_ZERO;
      lmode_q  <= MODE_HOLD;
      lsin_l_q <= 1'b0;
      lsin_r_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lmode_q  <= lmode_d;
      lsin_l_q <= lsin_l_d;
      lsin_r_q <= lsin_r_d;
    end
  end

  // Next-state logic; also picks which operation (live or latched) drives q.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lmode_d    = lmode_q;
    lsin_l_d   = lsin_l_q;
    lsin_r_d   = lsin_r_q;
    q_en_s     = 1'b0;
    op_mode_s  = MODE_HOLD;
    op_sin_l_s = 1'b0;
    op_sin_r_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Start takes priority over en; q is untouched on this edge.
          lmode_d  = mode;
          lsin_l_d = sin_l;
          lsin_r_d = sin_r;
          if ((shamt_clip_s != CNT_ZERO) && is_shift_mode(mode)) begin
            cnt_d   = shamt_clip_s;
            state_d = ST_SHIFT;
          end else begin
            cnt_d   = CNT_ZERO;
            state_d = ST_DONE;
          end
        end else if (en) begin
          q_en_s     = 1'b1;
          op_mode_s  = mode;
          op_sin_l_s = sin_l;
          op_sin_r_s = sin_r;
        end else begin
          q_en_s = 1'b0;
        end
      end
      ST_SHIFT: begin
        q_en_s     = 1'b1;
        op_mode_s  = lmode_q;
        op_sin_l_s = lsin_l_q;
        op_sin_r_s = lsin_r_q;
        cnt_d      = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        cnt_d   = CNT_ZERO;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Data path mux: value q takes on the next enabled edge.
  always_comb begin
    q_d = q_q;
    case (op_mode_s)
      MODE_LOAD: q_d = d;
      MODE_SHL:  q_d = {q_q[WIDTH-2:0], op_sin_l_s};
      MODE_SHR:  q_d = {op_sin_r_s, q_q[WIDTH-1:1]};
      MODE_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      MODE_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
      MODE_CLR:  q_d = RST_VAL;
      default:   q_d = q_q;
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_en_arst #(
      .RST_VAL(RST_VAL[i])
    ) u_bit (
      .clk(clk),
      .rst(rst),
      .en (q_en_s),
      .d  (q_d[i]),
      .q  (q_q[i])
    );
  end

  assign q      = q_q;
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];
  assign busy   = (state_q == ST_SHIFT);
  assign done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8): expected results are queued as
// each step is driven and checked after the following clock edge.
module tb_univ_shift_reg;
  import univ_shift_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] mode;
  logic [7:0] d;
  logic       sin_l;
  logic       sin_r;
  logic       start;
  logic [3:0] shamt;
  logic [7:0] q;
  logic       sout_l;
  logic       sout_r;
  logic       busy;
  logic       done;

  typedef struct {
    logic [7:0] q;
    logic       busy;
    logic       done;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(8), .RST_VAL(8'h00)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .mode  (mode),
    .d     (d),
    .sin_l (sin_l),
    .sin_r (sin_r),
    .start (start),
    .shamt (shamt),
    .q     (q),
    .sout_l(sout_l),
    .sout_r(sout_r),
    .busy  (busy),
    .done  (done)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] eq, input logic eb, input logic ed, input string tag);
    exp_t e;
    e.q    = eq;
    e.busy = eb;
    e.done = ed;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed=0 entries expected=1");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".q"},      q,                  e.q);
      chk({e.tag, ".busy"},   {7'd0, busy},       {7'd0, e.busy});
      chk({e.tag, ".done"},   {7'd0, done},       {7'd0, e.done});
      chk({e.tag, ".sout_l"}, {7'd0, sout_l},     {7'd0, e.q[7]});
      chk({e.tag, ".sout_r"}, {7'd0, sout_r},     {7'd0, e.q[0]});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    compare_front();
  endtask

  task automatic drive(input logic e, input logic [2:0] m, input logic [7:0] dv,
                       input logic sl, input logic sr, input logic st, input logic [3:0] sa);
    en    = e;
    mode  = m;
    d     = dv;
    sin_l = sl;
    sin_r = sr;
    start = st;
    shamt = sa;
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    #12;
    push(8'h00, 1'b0, 1'b0, "in_reset");
    compare_front();
    @(negedge clk);
    rst = 1'b1;
    push(8'h00, 1'b0, 1'b0, "after_reset");
    tick();

    // Single-cycle operations.
    drive(1'b1, MODE_LOAD, 8'hA5, 1'b0, 1'b0, 1'b0, 4'd0);
    push(8'hA5, 1'b0, 1'b0, "load_a5");
    tick();
    drive(1'b1, MODE_SHL, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0);
    push(8'h4B, 1'b0, 1'b0, "shl_sin1");
    tick();
    drive(1'b1, MODE_ROR, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    push(8'hA5, 1'b0, 1'b0, "ror");
    tick();
    drive(1'b0, MODE_LOAD, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    push(8'hA5, 1'b0, 1'b0, "en0_hold");
    tick();
    drive(1'b1, 3'd7, 8'h00, 1'b1, 1'b1, 1'b0, 4'd0);
    push(8'hA5, 1'b0, 1'b0, "mode7_hold");
    tick();
    drive(1'b1, MODE_SHR, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0);
    push(8'hD2, 1'b0, 1'b0, "shr_sin1");
    tick();
    drive(1'b1, MODE_CLR, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    push(8'h00, 1'b0, 1'b0, "clr");
    tick();
    drive(1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0, 1'b0, 4'd0);
    push(8'h81, 1'b0, 1'b0, "load_81");
    tick();

    // ROL burst of 3 with live inputs changing mid-burst.
    drive(1'b0, MODE_ROL, 8'h00, 1'b0, 1'b0, 1'b1, 4'd3);
    push(8'h81, 1'b1, 1'b0, "rol_start");
    tick();
    drive(1'b1, MODE_SHR, 8'hFF, 1'b1, 1'b1, 1'b1, 4'd7);
    push(8'h03, 1'b1, 1'b0, "rol_step1");
    tick();
    drive(1'b1, MODE_LOAD, 8'hFF, 1'b1, 1'b1, 1'b0, 4'd7);
    push(8'h06, 1'b1, 1'b0, "rol_step2");
    tick();
    drive(1'b1, MODE_CLR, 8'hFF, 1'b0, 1'b0, 1'b1, 4'd2);
    push(8'h0C, 1'b0, 1'b1, "rol_done");
    tick();
    drive(1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    push(8'h0C, 1'b0, 1'b0, "rol_idle");
    tick();

    // SHR burst with shamt beyond WIDTH: clipped to 8 steps, latched sin_r=0.
    drive(1'b1, MODE_LOAD, 8'hFF, 1'b0, 1'b0, 1'b0, 4'd0);
    push(8'hFF, 1'b0, 1'b0, "load_ff");
    tick();
    drive(1'b0, MODE_SHR, 8'h00, 1'b0, 1'b0, 1'b1, 4'd12);
    push(8'hFF, 1'b1, 1'b0, "shr_start");
    tick();
    drive(1'b1, MODE_ROL, 8'h00, 1'b1, 1'b1, 1'b0, 4'd0);
    for (int i = 1; i <= 8; i++) begin
      push(8'hFF >> i, (i < 8), (i == 8), $sformatf("shr_step%0d", i));
      tick();
    end
    drive(1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    push(8'h00, 1'b0, 1'b0, "shr_idle");
    tick();

    // Zero-length bursts: start beats en, q unchanged, done still pulses.
    drive(1'b1, MODE_LOAD, 8'h3C, 1'b0, 1'b0, 1'b0, 4'd0);
    push(8'h3C, 1'b0, 1'b0, "load_3c");
    tick();
    drive(1'b1, MODE_LOAD, 8'hFF, 1'b0, 1'b0, 1'b1, 4'd0);
    push(8'h3C, 1'b0, 1'b1, "start_en_zero");
    tick();
    drive(1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    push(8'h3C, 1'b0, 1'b0, "zero_idle");
    tick();
    drive(1'b0, MODE_ROL, 8'h00, 1'b0, 1'b0, 1'b1, 4'd0);
    push(8'h3C, 1'b0, 1'b1, "rol_shamt0");
    tick();
    drive(1'b0, MODE_LOAD, 8'hFF, 1'b0, 1'b0, 1'b1, 4'd5);
    push(8'h3C, 1'b0, 1'b0, "start_in_done_ignored");
    tick();
    drive(1'b0, MODE_CLR, 8'h00, 1'b0, 1'b0, 1'b1, 4'd5);
    push(8'h3C, 1'b0, 1'b1, "clr_nonshift_start");
    tick();
    drive(1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    push(8'h3C, 1'b0, 1'b0, "nonshift_idle");
    tick();

    // Asynchronous reset in the middle of a ROL burst.
    drive(1'b0, MODE_ROL, 8'h00, 1'b0, 1'b0, 1'b1, 4'd5);
    push(8'h3C, 1'b1, 1'b0, "abort_start");
    tick();
    drive(1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    push(8'h78, 1'b1, 1'b0, "abort_step1");
    tick();
    #3;
    rst = 1'b0;
    #1;
    push(8'h00, 1'b0, 1'b0, "async_reset");
    compare_front();
    push(8'h00, 1'b0, 1'b0, "reset_held");
    tick();
    #2;
    rst = 1'b1;
    drive(1'b1, MODE_LOAD, 8'h5A, 1'b0, 1'b0, 1'b0, 4'd0);
    push(8'h5A, 1'b0, 1'b0, "first_after_reset");
    tick();
    drive(1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    push(8'h5A, 1'b0, 1'b0, "no_done_after_abort");
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
